mcp3008_scan_ctrl: RTL and testbench
====================================

Name: mcp3008_scan_ctrl

Overview:
Sequencer and arbiter for the 8-channel, 10-bit SPI ADC on the Pmod_ADC board.
- Generates SCLK, CS_n and MOSI, and captures MISO.
- Issues one conversion frame per grant.
- Shares the converter between two requesters: a continuous round-robin scan over enabled channels, and a higher-priority one-shot request port.
- Sits between the ADC pins and consumers such as the accel mapper and the 7-seg display logic.

Parameters:
- CLK_DIV, 27, clk cycles per SCLK half-period (>=1); SCLK period = 2*CLK_DIV clk.
- CS_IDLE, 2, full SCLK periods CS_n is held high between frames (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- scan_en  in  1  level; enables round-robin scanning
- ch_en  in  8  scan channel enable mask, bit n = channel n
- diff_mode  in  1  1 = differential (SGL/DIFF bit 0), 0 = single-ended
- req_valid  in  1  one-shot conversion request
- req_ch  in  3  channel for the one-shot request
- req_ready  out  1  request accepted this cycle (valid&ready handshake)
- sclk  out  1  ADC serial clock
- cs_n  out  1  ADC chip select, active low
- mosi  out  1  ADC DIN
- miso  in  1  ADC DOUT (already synchronised externally)
- res_valid  out  1  one-clk pulse, result fields valid
- res_ch  out  3  channel of result
- res_src  out  1  1 = one-shot request, 0 = scan
- res_data  out  10  conversion result
- busy  out  1  frame in progress (cs_n low or CS_IDLE hold)

Behaviour:
- Reset values: sclk=0, cs_n=1, mosi=0, req_ready=0, res_valid=0, res_ch=0, res_src=0, res_data=0, busy=0, last_scan_ch=7. Asserting rst mid-frame aborts at once; no res_valid is produced.
- FSM states:
  - IDLE: arbitrates every clk.
    - If req_valid: pulse req_ready for 1 clk, latch req_ch with src=1, go SETUP.
    - Else if scan_en and ch_en!=0: pick the first enabled channel after last_scan_ch (wraps 7->0), update last_scan_ch, src=0, go SETUP.
    - Else stay in IDLE.
  - SETUP: cs_n=0, sclk=0, mosi=start bit (1); hold one half-period; go SHIFT.
  - SHIFT: 17 SCLK periods, each low half then high half, with sclk rising mid-period.
    - MOSI changes only while sclk is low, before the rising edge. Period 1 = 1 (start), 2 = ~diff_mode, 3..5 = ch[2:0] MSB first, 6..17 = 0.
    - Period 6 is the sample period and period 7 is the null bit; neither is captured.
    - MISO is captured on rising edges of periods 8..17 into res_data[9..0], MSB first.
  - DONE: 1 clk; sclk=0, cs_n=1, res_valid=1, res_ch/res_src/res_data updated; go HOLD.
  - HOLD: cs_n=1 for CS_IDLE*2*CLK_DIV clk; go IDLE.
- res_data/res_ch/res_src hold their value until the next DONE.
- Latency: a request accepted in IDLE gives res_valid exactly 1 + CLK_DIV + 34*CLK_DIV clk later.
- scan_en deasserting, or ch_en changing, mid-frame: the current frame completes and reports. ch_en is sampled only in IDLE.
- req_valid and a scan candidate in the same IDLE cycle: the request wins; the scan pointer is not advanced.
- ch_en with a single bit set: that channel repeats back-to-back, each frame separated by HOLD.
- req_ready is never asserted outside IDLE.
- busy = state != IDLE.

Optional Feature:
PMOD_ADC_RESULT_BANK_EN.
- Defined: adds a bank of 8 x 10-bit registers (reset 0) written at DONE for scan results only. Adds ports rd_ch in 3 and rd_data out 10; rd_data is the registered bank[rd_ch], 1 clk latency.
- Undefined: no bank and no rd_* ports.

Decomposition:
- Package mcp3008_pkg holds:
  - state enum (IDLE, SETUP, SHIFT, DONE, HOLD)
  - FRAME_BITS=17, CMD_BITS=5, DATA_FIRST=8, DATA_BITS=10, NUM_CH=8
  - channel typedef logic[2:0], result typedef logic[9:0]
- One sub-module: mcp3008_rr_pick. Combinational next-enabled-channel search given mask and last index, with a found flag.

Test Plan:
1. CLK_DIV=2, one-shot req_ch=5, diff_mode=0, ADC model returns 0x2A7 -> MOSI bits 1,1,1,0,1, res_valid pulses once after 71 clk, res_data=0x2A7, res_ch=5, res_src=1.
2. scan_en=1, ch_en=8'b1000_0101 -> result channel order 0,2,7,0,2; HOLD between frames is exactly 8 clk (CS_IDLE=2).
3. Scan active and req_valid for ch3 held while a frame runs -> req_ready pulses only in the next IDLE; ch3 result precedes the next scan channel, and the scan order is otherwise unbroken.
4. rst asserted during SHIFT period 10 -> cs_n=1 and sclk=0 asynchronously, no res_valid; after release the next scan starts at channel 0.
5. scan_en=1, ch_en=0, no request -> cs_n stays 1 and busy=0 for 1000 clk. Then ch_en=8'h10 -> continuous ch4 frames.
6. With PMOD_ADC_RESULT_BANK_EN defined: scan ch1=0x3FF, ch6=0x001, rd_ch=6 -> rd_data=0x001 one clk later. A one-shot on ch6 returning 0x155 leaves bank[6]=0x001.

Source files
------------

// File: rtl/mcp3008_pkg.sv
// Shared types and constants for the MCP3008 scan controller.
// Optional result bank is enabled with PMOD_ADC_RESULT_BANK_EN (see top).
package mcp3008_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, HOLD} state_t;

  localparam int FRAME_BITS = 17;
  localparam int CMD_BITS   = 5;
  localparam int DATA_FIRST = 8;
  localparam int DATA_BITS  = 10;
  localparam int NUM_CH     = 8;

  typedef logic [2:0]           ch_t;
  typedef logic [DATA_BITS-1:0] res_t;

  // DIN value for a 1-based SCLK period: start, SGL/DIFF, D2..D0, then zeros.
  function automatic logic cmd_bit(input logic [4:0] period, input logic diff, input ch_t ch);
    case (period)
      5'd1:    return 1'b1;
      5'd2:    return ~diff;
      5'd3:    return ch[2];
      5'd4:    return ch[1];
      5'd5:    return ch[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mcp3008_rr_pick.sv
// Round-robin search: first enabled channel strictly after i_last, wrapping
// back to i_last itself so a single-bit mask repeats.
module mcp3008_rr_pick
  import mcp3008_pkg::*;
(
  input  logic [NUM_CH-1:0] i_mask,
  input  ch_t               i_last,
  output ch_t               o_ch,
  output logic              o_found
);

  always_comb begin
    logic [3:0] w_sum;
    o_found = |i_mask;
    o_ch    = i_last;
    w_sum   = '0;
    // Walk farthest to nearest so the nearest enabled channel wins.
    for (int k = NUM_CH; k >= 1; k--) begin
      w_sum = {1'b0, i_last} + 4'(k);
      if (i_mask[w_sum[2:0]]) o_ch = w_sum[2:0];
    end
  end

endmodule

// File: rtl/mcp3008_scan_ctrl.sv
// MCP3008 frame sequencer with one-shot/scan arbitration.
// Define PMOD_ADC_RESULT_BANK_EN to add a readable bank of the latest scan results.
module mcp3008_scan_ctrl
  import mcp3008_pkg::*;
#(
  parameter int CLK_DIV = 27,
  parameter int CS_IDLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_en,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              diff_mode,
  input  logic              req_valid,
  input  logic [2:0]        req_ch,
  output logic              req_ready,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso,
  output logic              res_valid,
  output logic [2:0]        res_ch,
  output logic              res_src,
  output logic [9:0]        res_data,
`ifdef PMOD_ADC_RESULT_BANK_EN
  input  logic [2:0]        rd_ch,
  output logic [9:0]        rd_data,
`endif
  output logic              busy
);

  localparam int HOLD_CYC = CS_IDLE * 2 * CLK_DIV;
  localparam int CW       = $clog2(HOLD_CYC + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [5:0]    HALF_LAST = 6'(2 * FRAME_BITS - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [5:0]    r_half;
  ch_t           r_ch;
  ch_t           r_last;
  logic          r_src;
  logic          r_diff;
  res_t          r_shift;
  logic          r_sclk, r_cs_n, r_mosi, r_busy;
  logic          r_res_valid, r_res_src;
  ch_t           r_res_ch;
  res_t          r_res_data;

  ch_t        w_pick;
  logic       w_found;
  logic [5:0] w_half_nx;
  logic [4:0] w_period_nx;
  logic       w_frame_end;

  mcp3008_rr_pick u_pick (
    .i_mask  (ch_en),
    .i_last  (r_last),
    .o_ch    (w_pick),
    .o_found (w_found)
  );

  assign w_half_nx   = r_half + 6'd1;
  assign w_period_nx = w_half_nx[5:1] + 5'd1;
  assign w_frame_end = (r_state == SHIFT) && (r_cnt == DIV_LAST) && (r_half == HALF_LAST);

  // The handshake must complete in the arbitration cycle itself, so ready is combinational.
  assign req_ready = (r_state == IDLE) && req_valid && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_half      <= '0;
      r_ch        <= '0;
      r_last      <= 3'd7;
      r_src       <= 1'b0;
      r_diff      <= 1'b0;
      r_shift     <= '0;
      r_sclk      <= 1'b0;
      r_cs_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_ch    <= '0;
      r_res_src   <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_res_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt  <= '0;
          r_half <= '0;
          if (req_valid || (scan_en && w_found)) begin
            r_state <= SETUP;
            r_cs_n  <= 1'b0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b1;
            r_busy  <= 1'b1;
            r_diff  <= diff_mode;
          end
          if (req_valid) begin
            r_ch  <= req_ch;
            r_src <= 1'b1;
          end else if (scan_en && w_found) begin
            r_ch   <= w_pick;
            r_last <= w_pick;
            r_src  <= 1'b0;
          end
        end
        SETUP: begin
          if (r_cnt == DIV_LAST) begin
            r_cnt   <= '0;
            r_state <= SHIFT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (r_cnt != DIV_LAST) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
            if (w_frame_end) begin
              r_state     <= DONE;
              r_sclk      <= 1'b0;
              r_cs_n      <= 1'b1;
              r_mosi      <= 1'b0;
              r_res_valid <= 1'b1;
              r_res_ch    <= r_ch;
              r_res_src   <= r_src;
              r_res_data  <= r_shift;
            end else begin
              r_half <= w_half_nx;
              r_sclk <= w_half_nx[0];
              // Falling edge: present next DIN bit. Rising edge: sample DOUT.
              if (!w_half_nx[0])
                r_mosi <= cmd_bit(w_period_nx, r_diff, r_ch);
              else if (w_period_nx >= 5'(DATA_FIRST))
                r_shift <= {r_shift[DATA_BITS-2:0], miso};
            end
          end
        end
        DONE: begin
          r_cnt   <= '0;
          r_state <= HOLD;
        end
        HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sclk      = r_sclk;
  assign cs_n      = r_cs_n;
  assign mosi      = r_mosi;
  assign busy      = r_busy;
  assign res_valid = r_res_valid;
  assign res_ch    = r_res_ch;
  assign res_src   = r_res_src;
  assign res_data  = r_res_data;

`ifdef PMOD_ADC_RESULT_BANK_EN
  logic [NUM_CH-1:0][DATA_BITS-1:0] r_bank;
  res_t                             r_rd;

  // Only scan results land in the bank; one-shots leave it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bank <= '0;
      r_rd   <= '0;
    end else begin
      if (w_frame_end && !r_src) r_bank[r_ch] <= r_shift;
      r_rd <= r_bank[rd_ch];
    end
  end

  assign rd_data = r_rd;
`endif

endmodule

// File: tb/tb_mcp3008_scan_ctrl.sv
// Self-checking bench: cycle-level expectation model plus an MCP3008 pin model.
module tb_mcp3008_scan_ctrl;

  localparam int CLK_DIV = 2;
  localparam int CS_IDLE = 2;
  localparam int L = 1 + CLK_DIV + 34 * CLK_DIV;  // accept -> res_valid
  localparam int H = CS_IDLE * 2 * CLK_DIV;       // HOLD length

  logic       clk = 1'b0, rst = 1'b1;
  logic       scan_en = 1'b0, diff_mode = 1'b0, req_valid = 1'b0, miso = 1'b0;
  logic [7:0] ch_en = 8'h00;
  logic [2:0] req_ch = 3'd0;
  logic       req_ready, sclk, cs_n, mosi, res_valid, res_src, busy;
  logic [2:0] res_ch;
  logic [9:0] res_data;
`ifdef PMOD_ADC_RESULT_BANK_EN
  logic [2:0] rd_ch = 3'd0;
  logic [9:0] rd_data;
`endif

  always #5 clk = ~clk;

  mcp3008_scan_ctrl #(.CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .ch_en(ch_en), .diff_mode(diff_mode),
    .req_valid(req_valid), .req_ch(req_ch), .req_ready(req_ready),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .res_valid(res_valid), .res_ch(res_ch), .res_src(res_src), .res_data(res_data),
`ifdef PMOD_ADC_RESULT_BANK_EN
    .rd_ch(rd_ch), .rd_data(rd_data),
`endif
    .busy(busy)
  );

  typedef struct {int ch; int src; int sgl;} exp_t;
  typedef struct {int start; int sgl; int ch; int val; int cmd;} adc_t;
  typedef struct {int ch; int gap; int data; int lat; int cmd;} lit_t;

  exp_t exp_q[$];
  adc_t adc_q[$];
  lit_t lit_q[$];
  int   adc_val[8];
  int   checks = 0, failures = 0, nres = 0, tmo = 0, done = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- ADC pin model ----------------
  int         a_r = 0, a_val = 0;
  logic [4:0] a_cmd = '0;
  logic [2:0] a_chv = '0;

  always @(posedge sclk or posedge cs_n) begin
    if (cs_n) a_r = 0;
    else begin
      a_r++;
      if (a_r <= 5) a_cmd = {a_cmd[3:0], mosi};
      if (a_r == 5) begin a_chv = a_cmd[2:0]; a_val = adc_val[a_chv]; end
      if (a_r == 17)
        adc_q.push_back('{start: int'(a_cmd[4]), sgl: int'(a_cmd[3]), ch: int'(a_cmd[2:0]),
                          val: a_val, cmd: int'(a_cmd)});
    end
  end

  always @(negedge sclk)
    miso = (a_r + 1 >= 8 && a_r + 1 <= 17) ? a_val[17 - (a_r + 1)] : 1'b0;

  // ---------------- expectation model + compare ----------------
  int cyc = 0, nidle = 0, fs = -1, last = 7, acc_cyc = -1000, prev_rv = -1000;
`ifdef PMOD_ADC_RESULT_BANK_EN
  int bmodel[8];
  int rd_exp = 0;
`endif

  always @(negedge clk) begin
    int e_cs, e_sclk, e_busy, e_rv, e_rr, d, sel;
    exp_t e;
    adc_t a;
    lit_t l;
    if (rst) begin
      chk("rst_cs_n", int'(cs_n), 1);
      chk("rst_sclk", int'(sclk), 0);
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_req_ready", int'(req_ready), 0);
      exp_q.delete(); adc_q.delete();
      last = 7; fs = -1; nidle = cyc + 1;
`ifdef PMOD_ADC_RESULT_BANK_EN
      for (int i = 0; i < 8; i++) bmodel[i] = 0;
      rd_exp = 0;
`endif
    end else begin
      e_rv = 0; e_rr = 0;
      if (cyc == nidle) begin
        e_busy = 0; e_cs = 1; e_sclk = 0; e_rr = int'(req_valid);
        if (req_valid) begin
          exp_q.push_back('{ch: int'(req_ch), src: 1, sgl: int'(!diff_mode)});
          fs = cyc; nidle = cyc + L + H + 1;
        end else if (scan_en && ch_en != 0) begin
          sel = -1;
          for (int k = 1; k <= 8; k++) if (sel < 0 && ch_en[(last + k) % 8]) sel = (last + k) % 8;
          last = sel;
          exp_q.push_back('{ch: sel, src: 0, sgl: int'(!diff_mode)});
          fs = cyc; nidle = cyc + L + H + 1;
        end else nidle = cyc + 1;
      end else begin
        d = cyc - fs;
        e_busy = 1; e_cs = (d < L) ? 0 : 1; e_sclk = 0;
        if (d > CLK_DIV && d < L) e_sclk = ((d - 1 - CLK_DIV) / CLK_DIV) % 2;
        e_rv = (d == L) ? 1 : 0;
      end
      chk("busy", int'(busy), e_busy);
      chk("cs_n", int'(cs_n), e_cs);
      chk("sclk", int'(sclk), e_sclk);
      chk("res_valid", int'(res_valid), e_rv);
      chk("req_ready", int'(req_ready), e_rr);
`ifdef PMOD_ADC_RESULT_BANK_EN
      chk("rd_data", int'(rd_data), rd_exp);
`endif
      if (req_ready) acc_cyc = cyc;
      if (res_valid) begin
        e = '{ch: -1, src: -1, sgl: -1};
        a = '{start: -1, sgl: -1, ch: -1, val: -1, cmd: -1};
        if (exp_q.size() == 0) chk("res_expected", 0, 1);
        else begin
          e = exp_q.pop_front();
          chk("res_ch", int'(res_ch), e.ch);
          chk("res_src", int'(res_src), e.src);
        end
        if (adc_q.size() == 0) chk("adc_frame_complete", 0, 1);
        else begin
          a = adc_q.pop_front();
          chk("res_data", int'(res_data), a.val);
          chk("mosi_start", a.start, 1);
          chk("mosi_sgl", a.sgl, e.sgl);
          chk("mosi_ch", a.ch, e.ch);
        end
        if (lit_q.size() != 0) begin
          l = lit_q.pop_front();
          chk("lit_ch", int'(res_ch), l.ch);
          if (l.gap >= 0)  chk("lit_gap", cyc - prev_rv, l.gap);
          if (l.data >= 0) chk("lit_data", int'(res_data), l.data);
          if (l.lat >= 0)  chk("lit_latency", cyc - acc_cyc, l.lat);
          if (l.cmd >= 0)  chk("lit_mosi_cmd", a.cmd, l.cmd);
        end
`ifdef PMOD_ADC_RESULT_BANK_EN
        if (e.src == 0 && e.ch >= 0) bmodel[e.ch] = a.val;
`endif
        prev_rv = cyc;
        nres++;
      end
`ifdef PMOD_ADC_RESULT_BANK_EN
      rd_exp = bmodel[rd_ch];
`endif
    end
    if (done != 0) begin
      chk("no_timeout", tmo, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_req(input int ch);
    int n = 0;
    tick();
    req_ch = 3'(ch); req_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!req_ready && n < 2000);
    if (!req_ready) tmo++;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_res(input int target);
    int n = 0;
    while (nres < target && n < 5000) begin @(negedge clk); n++; end
    if (nres < target) tmo++;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 2000);
    if (busy) tmo++;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 8; i++) adc_val[i] = int'($urandom_range(0, 1023));
    adc_val[5] = 'h2A7;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // One-shot ch5, single-ended
    lit_q.push_back('{ch: 5, gap: -1, data: 'h2A7, lat: 71, cmd: 5'b11101});
    send_req(5);
    wait_res(1);

    // Scan order over mask 1000_0101 with fixed frame spacing
    lit_q.push_back('{ch: 0, gap: -1, data: -1, lat: -1, cmd: -1});
    lit_q.push_back('{ch: 2, gap: 80, data: -1, lat: -1, cmd: -1});
    lit_q.push_back('{ch: 7, gap: 80, data: -1, lat: -1, cmd: -1});
    lit_q.push_back('{ch: 0, gap: 80, data: -1, lat: -1, cmd: -1});
    lit_q.push_back('{ch: 2, gap: 80, data: -1, lat: -1, cmd: -1});
    tick();
    ch_en = 8'b1000_0101; scan_en = 1'b1;
    wait_res(6);
    tick(); scan_en = 1'b0;
    wait_idle();

    // One-shot raised while a scan frame runs
    tick(); scan_en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (cs_n && n < 2000);
    send_req(3);
    wait_res(nres + 3);
    tick(); scan_en = 1'b0;
    wait_idle();

    // Reset in SHIFT period 10
    tick(); scan_en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (cs_n && n < 2000);
    repeat (1 + CLK_DIV + 18 * CLK_DIV) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    lit_q.push_back('{ch: 0, gap: -1, data: -1, lat: -1, cmd: -1});
    #1 rst = 1'b0;
    wait_res(nres + 1);
    tick(); scan_en = 1'b0;
    wait_idle();

    // Empty mask stays quiet, then single channel repeats
    tick(); scan_en = 1'b1; ch_en = 8'h00;
    repeat (1000) @(posedge clk);
    lit_q.push_back('{ch: 4, gap: -1, data: -1, lat: -1, cmd: -1});
    lit_q.push_back('{ch: 4, gap: 80, data: -1, lat: -1, cmd: -1});
    lit_q.push_back('{ch: 4, gap: 80, data: -1, lat: -1, cmd: -1});
    #1 ch_en = 8'h10;
    wait_res(nres + 3);
    tick(); scan_en = 1'b0;
    wait_idle();

    // Randomised traffic
    for (int it = 0; it < 150; it++) begin
      repeat ($urandom_range(1, 60)) @(posedge clk);
      #1;
      scan_en   = ($urandom_range(0, 3) != 0);
      diff_mode = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 3))
        0: ch_en = 8'h00;
        1: ch_en = 8'(1 << $urandom_range(0, 7));
        default: ch_en = 8'($urandom);
      endcase
      adc_val[$urandom_range(0, 7)] = int'($urandom_range(0, 1023));
`ifdef PMOD_ADC_RESULT_BANK_EN
      rd_ch = 3'($urandom_range(0, 7));
`endif
      if ($urandom_range(0, 2) == 0) send_req(int'($urandom_range(0, 7)));
    end
    tick(); scan_en = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);
    done = 1;
  end

endmodule
